id_ex_stage: RTL and testbench

ID/EX pipeline stage of the five-stage MIPS pipeline. Registers the decode-stage outputs (register operands, the 32-bit immediate and 32-bit shift amount produced by the extend units, decoded control) into the EX stage. Detects load-use hazards and inserts bubbles. Precomputes registered forwarding selects for the EX operand muxes. Keeps a saturating stall-cycle counter for the performance CSRs.

---
 rtl/id_ex_stage.sv | 103 ++++++++++
 tb/tb_id_ex_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, forwarding selects and stall counter
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_qa,
  input  logic [31:0]      id_qb,
  input  logic [31:0]      id_imm32,
  input  logic [31:0]      id_sa32,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_wmem,
  input  logic             id_aluimm,
  input  logic             id_shift,
  input  logic             id_regrt,
  input  logic             id_jal,
  input  logic [3:0]       id_aluc,
  input  logic             flush,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_rn,
  output logic             stall,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_qa,
  output logic [31:0]      ex_qb,
  output logic [31:0]      ex_imm32,
  output logic [31:0]      ex_sa32,
  output logic [4:0]       ex_rn,
  output logic             ex_wreg,
  output logic             ex_m2reg,
  output logic             ex_wmem,
  output logic             ex_aluimm,
  output logic             ex_shift,
  output logic             ex_jal,
  output logic [3:0]       ex_aluc,
  output logic [1:0]       ex_fwda,
  output logic [1:0]       ex_fwdb,
  output logic [CNT_W-1:0] stall_count
);
  logic [4:0] id_rn;
  logic       ld_hz, ex_alu_wr, ex_ld_wr;
  logic [1:0] fwda, fwdb;
  assign id_rn     = id_jal ? 5'd31 : (id_regrt ? id_rt : id_rd);
  assign ex_alu_wr = ex_valid & ex_wreg & ~ex_m2reg & (ex_rn != 5'd0);
  assign ex_ld_wr  = ex_valid & ex_wreg & ex_m2reg & (ex_rn != 5'd0);
  assign ld_hz     = ex_ld_wr & ((id_use_rs & (id_rs == ex_rn)) | (id_use_rt & (id_rt == ex_rn)));
  assign stall     = id_valid & ld_hz & ~flush & ~rst;
  // the EX-stage producer is younger than MEM, so its value wins
  assign fwda = (id_use_rs & ex_alu_wr & (ex_rn == id_rs)) ? 2'b01 :
                (id_use_rs & mem_wreg & (mem_rn != 5'd0) & (mem_rn == id_rs)) ? 2'b10 : 2'b00;
  assign fwdb = (id_use_rt & ex_alu_wr & (ex_rn == id_rt)) ? 2'b01 :
                (id_use_rt & mem_wreg & (mem_rn != 5'd0) & (mem_rn == id_rt)) ? 2'b10 : 2'b00;
  always_ff @(posedge clk) begin
    if (rst || flush || stall) begin
      ex_valid  <= 1'b0;
      ex_pc     <= '0;
      ex_qa     <= '0;
      ex_qb     <= '0;
      ex_imm32  <= '0;
      ex_sa32   <= '0;
      ex_rn     <= '0;
      ex_wreg   <= 1'b0;
      ex_m2reg  <= 1'b0;
      ex_wmem   <= 1'b0;
      ex_aluimm <= 1'b0;
      ex_shift  <= 1'b0;
      ex_jal    <= 1'b0;
      ex_aluc   <= '0;
      ex_fwda   <= '0;
      ex_fwdb   <= '0;
    end else begin
      ex_valid  <= id_valid;
      ex_pc     <= id_pc;
      ex_qa     <= id_qa;
      ex_qb     <= id_qb;
      ex_imm32  <= id_imm32;
      ex_sa32   <= id_sa32;
      ex_rn     <= id_rn;
      ex_wreg   <= id_valid & id_wreg;
      ex_m2reg  <= id_valid & id_m2reg;
      ex_wmem   <= id_valid & id_wmem;
      ex_aluimm <= id_valid & id_aluimm;
      ex_shift  <= id_valid & id_shift;
      ex_jal    <= id_valid & id_jal;
      ex_aluc   <= id_valid ? id_aluc : 4'd0;
      ex_fwda   <= id_valid ? fwda : 2'b00;
      ex_fwdb   <= id_valid ? fwdb : 2'b00;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) stall_count <= '0;
    else if (stall && stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + 1'b1;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed tests for the ID/EX stage, plus a 2-bit counter instance for saturation
module tb_id_ex_stage;
  logic clk = 0, rst = 1;
  logic id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_regrt, id_jal;
  logic [31:0] id_pc, id_qa, id_qb, id_imm32, id_sa32;
  logic [4:0] id_rs, id_rt, id_rd, mem_rn;
  logic [3:0] id_aluc;
  logic flush, mem_wreg, mem_m2reg;
  logic stall, ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_shift, ex_jal;
  logic [31:0] ex_pc, ex_qa, ex_qb, ex_imm32, ex_sa32;
  logic [4:0] ex_rn;
  logic [3:0] ex_aluc;
  logic [1:0] ex_fwda, ex_fwdb;
  logic [15:0] stall_count;
  logic s_stall, s_ex_valid, s_ex_wreg, s_ex_m2reg, s_ex_wmem, s_ex_aluimm, s_ex_shift, s_ex_jal;
  logic [31:0] s_ex_pc, s_ex_qa, s_ex_qb, s_ex_imm32, s_ex_sa32;
  logic [4:0] s_ex_rn;
  logic [3:0] s_ex_aluc;
  logic [1:0] s_ex_fwda, s_ex_fwdb, s_stall_count;
  int tests = 0, fails = 0;
  logic [15:0] exp_cnt = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_qa(id_qa), .id_qb(id_qb),
    .id_imm32(id_imm32), .id_sa32(id_sa32), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wmem(id_wmem), .id_aluimm(id_aluimm), .id_shift(id_shift), .id_regrt(id_regrt),
    .id_jal(id_jal), .id_aluc(id_aluc), .flush(flush), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .mem_rn(mem_rn), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_qa(ex_qa), .ex_qb(ex_qb),
    .ex_imm32(ex_imm32), .ex_sa32(ex_sa32), .ex_rn(ex_rn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
    .ex_wmem(ex_wmem), .ex_aluimm(ex_aluimm), .ex_shift(ex_shift), .ex_jal(ex_jal), .ex_aluc(ex_aluc),
    .ex_fwda(ex_fwda), .ex_fwdb(ex_fwdb), .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_qa(id_qa), .id_qb(id_qb),
    .id_imm32(id_imm32), .id_sa32(id_sa32), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wmem(id_wmem), .id_aluimm(id_aluimm), .id_shift(id_shift), .id_regrt(id_regrt),
    .id_jal(id_jal), .id_aluc(id_aluc), .flush(flush), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .mem_rn(mem_rn), .stall(s_stall), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_qa(s_ex_qa),
    .ex_qb(s_ex_qb), .ex_imm32(s_ex_imm32), .ex_sa32(s_ex_sa32), .ex_rn(s_ex_rn), .ex_wreg(s_ex_wreg),
    .ex_m2reg(s_ex_m2reg), .ex_wmem(s_ex_wmem), .ex_aluimm(s_ex_aluimm), .ex_shift(s_ex_shift),
    .ex_jal(s_ex_jal), .ex_aluc(s_ex_aluc), .ex_fwda(s_ex_fwda), .ex_fwdb(s_ex_fwdb),
    .stall_count(s_stall_count)
  );

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic urs, input logic urt, input logic wr, input logic m2, input logic rgt);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_use_rs = urs; id_use_rt = urt;
    id_wreg = wr; id_m2reg = m2; id_regrt = rgt; id_aluimm = rgt; id_wmem = 0; id_shift = 0;
    id_jal = 0; id_aluc = 4'd2; id_pc = 32'h0040_0100; id_qa = 32'h1111_1111; id_qb = 32'h2222_2222;
    id_imm32 = 32'h0000_0004; id_sa32 = 32'd0;
  endtask

  task automatic drive_lw8();
    drive(1, 5'd29, 5'd8, 5'd0, 1, 0, 1, 1, 1);
  endtask

  task automatic drive_add_dep8();
    drive(1, 5'd8, 5'd9, 5'd10, 1, 1, 1, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; flush = 0; mem_wreg = $urandom; mem_m2reg = $urandom; mem_rn = 5'($urandom);
    drive(1, 5'($urandom), 5'($urandom), 5'($urandom), 1, 1, 1, 1, 0);
    id_pc = $urandom; id_qa = $urandom; id_wmem = 1; id_jal = 1;
    tick(); tick();
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", stall); end
    tests++; if ({ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_shift, ex_jal} !== 7'd0) begin
      fails++; $display("FAIL reset_ctrl got %b exp 0", {ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_shift, ex_jal}); end
    tests++; if ({ex_pc, ex_qa, ex_qb, ex_imm32, ex_sa32, ex_rn, ex_aluc, ex_fwda, ex_fwdb} !== '0) begin
      fails++; $display("FAIL reset_data got pc=%h rn=%0d fwda=%b exp 0", ex_pc, ex_rn, ex_fwda); end
    tests++; if (stall_count !== 16'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", stall_count); end
    @(negedge clk);
    rst = 0; mem_wreg = 0; mem_m2reg = 0; mem_rn = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_pass_through();
    @(negedge clk);
    drive(1, 5'd4, 5'd9, 5'd3, 1, 0, 1, 0, 1);
    id_pc = 32'h0040_0010; id_imm32 = 32'hFFFF_8000; id_sa32 = 32'h0000_001F; id_qa = 32'hDEAD_BEEF;
    tick();
    tests++; if (ex_pc !== 32'h0040_0010) begin fails++; $display("FAIL pt_pc got %h exp 00400010", ex_pc); end
    tests++; if (ex_imm32 !== 32'hFFFF_8000) begin fails++; $display("FAIL pt_imm got %h exp ffff8000", ex_imm32); end
    tests++; if (ex_rn !== 5'd9) begin fails++; $display("FAIL pt_rn got %0d exp 9", ex_rn); end
    tests++; if ({ex_valid, ex_wreg, ex_aluimm} !== 3'b111) begin fails++; $display("FAIL pt_ctrl got %b exp 111", {ex_valid, ex_wreg, ex_aluimm}); end
    tests++; if ({ex_fwda, ex_fwdb} !== 4'b0000) begin fails++; $display("FAIL pt_fwd got %b exp 0000", {ex_fwda, ex_fwdb}); end
    tests++; if ({ex_qa, ex_sa32} !== {32'hDEAD_BEEF, 32'h1F}) begin fails++; $display("FAIL pt_qa_sa got %h %h exp deadbeef 1f", ex_qa, ex_sa32); end
    @(negedge clk);
    drive(1, 5'd0, 5'd0, 5'd5, 0, 0, 1, 0, 1); id_jal = 1;
    tick();
    tests++; if ({ex_rn, ex_jal} !== {5'd31, 1'b1}) begin fails++; $display("FAIL pt_jal got rn=%0d jal=%b exp 31 1", ex_rn, ex_jal); end
    @(negedge clk);
    drive(0, 5'd1, 5'd2, 5'd3, 1, 1, 1, 1, 0); id_wmem = 1; id_pc = 32'h0040_0200;
    tick();
    tests++; if ({ex_valid, ex_wreg, ex_m2reg, ex_wmem} !== 4'b0000) begin fails++; $display("FAIL pt_invalid_ctrl got %b exp 0000", {ex_valid, ex_wreg, ex_m2reg, ex_wmem}); end
  endtask

  task automatic test_load_use();
    @(negedge clk); drive_lw8(); tick();
    @(negedge clk); drive_add_dep8(); #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall got %b exp 1", stall); end
    tick(); exp_cnt++;
    tests++; if (ex_valid !== 1'b0 || ex_wreg !== 1'b0) begin fails++; $display("FAIL lu_bubble got v=%b w=%b exp 0 0", ex_valid, ex_wreg); end
    tests++; if (stall_count !== exp_cnt) begin fails++; $display("FAIL lu_count got %0d exp %0d", stall_count, exp_cnt); end
    @(negedge clk); mem_wreg = 1; mem_m2reg = 1; mem_rn = 5'd8; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_stall_drop got %b exp 0", stall); end
    tick();
    tests++; if ({ex_valid, ex_rn, ex_fwda, ex_fwdb} !== {1'b1, 5'd10, 2'b10, 2'b00}) begin
      fails++; $display("FAIL lu_fwd got v=%b rn=%0d a=%b b=%b exp 1 10 10 00", ex_valid, ex_rn, ex_fwda, ex_fwdb); end
    tests++; if (stall_count !== exp_cnt) begin fails++; $display("FAIL lu_count_hold got %0d exp %0d", stall_count, exp_cnt); end
    @(negedge clk); mem_wreg = 0; mem_m2reg = 0; mem_rn = 0;
  endtask

  task automatic test_forward();
    @(negedge clk); drive(1, 5'd1, 5'd2, 5'd8, 1, 1, 1, 0, 0); tick();
    @(negedge clk); mem_wreg = 1; mem_rn = 5'd8; drive(1, 5'd8, 5'd3, 5'd11, 1, 1, 1, 0, 0); #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL fw_nostall got %b exp 0", stall); end
    tick();
    tests++; if ({ex_fwda, ex_fwdb} !== 4'b0100) begin fails++; $display("FAIL fw_priority got %b exp 0100", {ex_fwda, ex_fwdb}); end
    @(negedge clk); mem_rn = 5'd11; drive(1, 5'd4, 5'd11, 5'd12, 1, 1, 1, 0, 0); tick();
    tests++; if ({ex_fwda, ex_fwdb} !== 4'b0001) begin fails++; $display("FAIL fw_ex_b got %b exp 0001", {ex_fwda, ex_fwdb}); end
    @(negedge clk); mem_rn = 5'd4; drive(1, 5'd4, 5'd12, 5'd13, 1, 0, 1, 0, 0); tick();
    tests++; if ({ex_fwda, ex_fwdb} !== 4'b1000) begin fails++; $display("FAIL fw_mem_a_nouse_b got %b exp 1000", {ex_fwda, ex_fwdb}); end
    @(negedge clk); mem_rn = 5'd0; drive(1, 5'd1, 5'd2, 5'd0, 1, 1, 1, 0, 0); tick();
    @(negedge clk); drive(1, 5'd0, 5'd0, 5'd14, 1, 1, 1, 0, 0); tick();
    tests++; if ({ex_fwda, ex_fwdb} !== 4'b0000) begin fails++; $display("FAIL fw_zero got %b exp 0000", {ex_fwda, ex_fwdb}); end
    @(negedge clk); mem_wreg = 0; drive(1, 5'd29, 5'd0, 5'd0, 1, 0, 1, 1, 1); tick();
    @(negedge clk); drive(1, 5'd0, 5'd0, 5'd15, 1, 1, 1, 0, 0); #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_zero_stall got %b exp 0", stall); end
    tick();
  endtask

  task automatic test_flush();
    @(negedge clk); drive_lw8(); tick();
    @(negedge clk); drive_add_dep8(); flush = 1; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL fl_stall got %b exp 0", stall); end
    tick();
    tests++; if (ex_valid !== 1'b0 || ex_pc !== 32'd0) begin fails++; $display("FAIL fl_bubble got v=%b pc=%h exp 0 0", ex_valid, ex_pc); end
    tests++; if (stall_count !== exp_cnt) begin fails++; $display("FAIL fl_count got %0d exp %0d", stall_count, exp_cnt); end
    @(negedge clk); flush = 0;
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk); drive_lw8(); tick();
    @(negedge clk); drive_add_dep8(); rst = 1; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rs_stall got %b exp 0", stall); end
    tick(); exp_cnt = 0;
    tests++; if ({ex_valid, ex_rn, ex_wreg, ex_m2reg} !== 8'd0 || stall_count !== 16'd0) begin
      fails++; $display("FAIL rs_clear got v=%b rn=%0d cnt=%0d exp 0 0 0", ex_valid, ex_rn, stall_count); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_back_to_back_saturate();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive_lw8(); tick();
      @(negedge clk); drive_add_dep8(); #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sat_stall_%0d got %b exp 1", i, stall); end
      tick(); exp_cnt++;
    end
    tests++; if (stall_count !== exp_cnt) begin fails++; $display("FAIL sat_wide_count got %0d exp %0d", stall_count, exp_cnt); end
    tests++; if (s_stall_count !== 2'd3) begin fails++; $display("FAIL sat_narrow_count got %0d exp 3", s_stall_count); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_forward();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
